// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation classes, opcodes,
// FSM states and the compare-flag bundle.
package alu_pkg;

    localparam logic [1:0] OT_MOVE  = 2'b00;
    localparam logic [1:0] OT_ARITH = 2'b01;
    localparam logic [1:0] OT_LOGIC = 2'b10;
    localparam logic [1:0] OT_ILL   = 2'b11;

    localparam logic [3:0] OP_MOVE = 4'b0000;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_CMP = 4'b0110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic za;
        logic zb;
        logic eq;
        logic gt;
        logic lt;
    } cmp_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result channel of the sequential ALU: valid/ready request side
// carrying operands, valid/ready response side carrying result and flags.
interface alu_seq_if #(parameter int unsigned WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [3:0]       alu_opcode;
    logic [1:0]       alu_ot;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] addr_out;
    logic             za;
    logic             zb;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             carry;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, op1, op2, alu_opcode, alu_ot, out_ready,
        input  in_ready, out_valid, alu_out, res_hi, addr_out,
               za, zb, eq, gt, lt, carry, zero, err
    );

    modport slave (
        input  in_valid, op1, op2, alu_opcode, alu_ot, out_ready,
        output in_ready, out_valid, alu_out, res_hi, addr_out,
               za, zb, eq, gt, lt, carry, zero, err
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// o_done_c flags the final step; o_product_c then holds the full product.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done_c,
    output logic [2*WIDTH-1:0] o_product_c
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    w_acc_nxt;

    // Exposing the post-step accumulator lets the caller capture the product
    // on the same edge as the last step.
    always_comb begin
        w_acc_nxt = r_acc;
        if (r_mplier[0]) begin
            w_acc_nxt = r_acc + r_mcand;
        end
    end

    assign o_done_c    = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_product_c = w_acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= PW'(i_a);
            r_acc    <= '0;
            r_mplier <= i_b;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (o_done_c) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready channels: single-cycle move/arith/logic ops
// and an iterative multiply, with compare, carry, zero and error flags.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned XW  = WIDTH + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rdy_en;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu_out;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_addr_out;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;
    cmp_t             r_cmp;
    cmp_t             r_cmp_pend;

    logic             w_in_ready_c;
    logic             w_acc;
    logic             w_is_mul;
    logic             w_load_single;
    logic             w_load_mul;
    logic             w_mul_done_c;
    logic [PW-1:0]    w_product_c;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_addr;
    logic             w_carry;
    logic             w_err;
    cmp_t             w_cmp;

    always_comb begin
        w_cmp.za = (bus.op1 == '0);
        w_cmp.zb = (bus.op2 == '0);
        w_cmp.eq = (bus.op1 == bus.op2);
        w_cmp.gt = (bus.op1 > bus.op2);
        w_cmp.lt = (bus.op1 < bus.op2);
    end

    // Single-cycle result; MUL is only recognised here and handed off.
    always_comb begin
        w_res    = '0;
        w_addr   = '0;
        w_carry  = 1'b0;
        w_err    = 1'b0;
        w_is_mul = 1'b0;
        case (bus.alu_ot)
            OT_MOVE: begin
                if (bus.alu_opcode == OP_MOVE) begin
                    w_res  = bus.op1;
                    w_addr = bus.op2;
                end else begin
                    w_err = 1'b1;
                end
            end
            OT_ARITH: begin
                case (bus.alu_opcode)
                    OP_ADD:  {w_carry, w_res} = {1'b0, bus.op1} + {1'b0, bus.op2};
                    OP_SUB:  {w_carry, w_res} = {1'b0, bus.op1} - {1'b0, bus.op2};
                    OP_INC:  {w_carry, w_res} = {1'b0, bus.op1} + XW'(1);
                    OP_DEC:  {w_carry, w_res} = {1'b0, bus.op1} - XW'(1);
                    OP_MUL:  w_is_mul = 1'b1;
                    default: w_err = 1'b1;
                endcase
            end
            OT_LOGIC: begin
                case (bus.alu_opcode)
                    OP_AND:  w_res = bus.op1 & bus.op2;
                    OP_OR:   w_res = bus.op1 | bus.op2;
                    OP_XOR:  w_res = bus.op1 ^ bus.op2;
                    OP_NOT:  w_res = ~bus.op1;
                    OP_SHL:  w_res = bus.op1 << bus.op2[SHW-1:0];
                    OP_SHR:  w_res = bus.op1 >> bus.op2[SHW-1:0];
                    OP_CMP:  w_res = '0;
                    default: w_err = 1'b1;
                endcase
            end
            OT_ILL: w_err = 1'b1;
        endcase
    end

    // r_rdy_en keeps in_ready low through reset and for the first cycle after it.
    assign w_in_ready_c  = ((r_state == S_IDLE) && r_rdy_en)
                         || ((r_state == S_DONE) && bus.out_ready);
    assign w_acc         = bus.in_valid && w_in_ready_c;
    assign w_load_single = w_acc && !w_is_mul;
    assign w_load_mul    = (r_state == S_BUSY) && w_mul_done_c;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_mul_done_c) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    if (w_acc) begin
                        w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdy_en    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_rdy_en    <= 1'b1;
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    // Visible result registers only move when a result enters DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_out  <= '0;
            r_res_hi   <= '0;
            r_addr_out <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_err      <= 1'b0;
            r_cmp      <= '0;
            r_cmp_pend <= '0;
        end else begin
            if (w_acc && w_is_mul) begin
                r_cmp_pend <= w_cmp;
            end
            if (w_load_single) begin
                r_alu_out  <= w_res;
                r_res_hi   <= '0;
                r_addr_out <= w_addr;
                r_carry    <= w_carry;
                r_zero     <= (w_res == '0);
                r_err      <= w_err;
                r_cmp      <= w_cmp;
            end else if (w_load_mul) begin
                r_alu_out  <= w_product_c[WIDTH-1:0];
                r_res_hi   <= w_product_c[PW-1:WIDTH];
                r_addr_out <= '0;
                r_carry    <= 1'b0;
                r_zero     <= (w_product_c == '0);
                r_err      <= 1'b0;
                r_cmp      <= r_cmp_pend;
            end
        end
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_acc && w_is_mul),
        .i_a         (bus.op1),
        .i_b         (bus.op2),
        .o_done_c    (w_mul_done_c),
        .o_product_c (w_product_c)
    );

    assign bus.in_ready  = w_in_ready_c;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_out   = r_alu_out;
    assign bus.res_hi    = r_res_hi;
    assign bus.addr_out  = r_addr_out;
    assign bus.za        = r_cmp.za;
    assign bus.zb        = r_cmp.zb;
    assign bus.eq        = r_cmp.eq;
    assign bus.gt        = r_cmp.gt;
    assign bus.lt        = r_cmp.lt;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios with literal expectations plus
// randomized traffic checked against an arithmetic reference model.
module tb_alu_seq;
    localparam int W  = 16;
    localparam int VW = 3 * W + 8;
    typedef logic [VW-1:0] vec_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   due   = -1;
    int   acc_cyc = 0;
    logic rnd_rdy = 1'b0;
    logic hold = 1'b0;
    vec_t hold_vec;
    vec_t exp_q[$];
    vec_t got_q[$];
    int   got_cyc[$];

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [W-1:0] ad,
                                input logic za, input logic zb, input logic eq, input logic gt,
                                input logic lt, input logic cy, input logic z, input logic er);
        return {lo, hi, ad, za, zb, eq, gt, lt, cy, z, er};
    endfunction

    function automatic vec_t pack_out();
        return {bus.alu_out, bus.res_hi, bus.addr_out, bus.za, bus.zb, bus.eq,
                bus.gt, bus.lt, bus.carry, bus.zero, bus.err};
    endfunction

    // Reference: plain integer arithmetic modulo 2^W.
    function automatic vec_t model(input logic [1:0] ot, input logic [3:0] opc,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned m, ua, ub, res, hi, ad, t;
        logic cy, er;
        m = 64'd1 << W;
        ua = 64'(a); ub = 64'(b);
        res = 0; hi = 0; ad = 0; cy = 1'b0; er = 1'b0;
        case (ot)
            2'd0: if (opc == 4'd0) begin res = ua; ad = ub; end else er = 1'b1;
            2'd1: case (opc)
                4'd0: begin t = ua + ub; res = t % m; cy = (t >= m); end
                4'd1: begin res = (ua + m - ub) % m; cy = (ua < ub); end
                4'd2: begin t = ua + 1; res = t % m; cy = (t >= m); end
                4'd3: begin res = (ua + m - 1) % m; cy = (ua == 0); end
                4'd4: begin t = ua * ub; res = t % m; hi = t / m; end
                default: er = 1'b1;
            endcase
            2'd2: case (opc)
                4'd0: res = ua & ub;
                4'd1: res = ua | ub;
                4'd2: res = ua ^ ub;
                4'd3: res = m - 1 - ua;
                4'd4: res = (ua << (ub % W)) % m;
                4'd5: res = ua >> (ub % W);
                4'd6: res = 0;
                default: er = 1'b1;
            endcase
            default: er = 1'b1;
        endcase
        if (er) begin res = 0; hi = 0; ad = 0; cy = 1'b0; end
        return {W'(res), W'(hi), W'(ad), ua == 0, ub == 0, ua == ub, ua > ub, ua < ub,
                cy, (res == 0) && (hi == 0), er};
    endfunction

    // Compare process: timing rules, hold stability and result values.
    always @(negedge clk) begin
        vec_t cur;
        vec_t e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            due  = -1;
            hold = 1'b0;
        end else begin
            cur = pack_out();
            if (due >= 0) begin
                if (cyc == due) begin
                    check("latency", 64'(bus.out_valid), 64'd1);
                    due = -1;
                end else begin
                    check("busy_phase", 64'({bus.out_valid, bus.in_ready}), 64'd0);
                end
            end
            if (hold) check("hold_stable", 64'({bus.out_valid, cur}), 64'({1'b1, hold_vec}));
            hold     = bus.out_valid && !bus.out_ready;
            hold_vec = cur;
            if (bus.out_valid && bus.out_ready) begin
                check("result_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", 64'(cur), 64'(e));
                end
                got_q.push_back(cur);
                got_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.alu_ot, bus.alu_opcode, bus.op1, bus.op2));
                acc_cyc = cyc;
                due = cyc + (((bus.alu_ot == 2'd1) && (bus.alu_opcode == 4'd4)) ? W + 1 : 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [1:0] ot, input logic [3:0] opc,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.alu_ot = ot; bus.alu_opcode = opc; bus.op1 = a; bus.op2 = b;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        check("accept", 64'(acc), 64'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic seen;
        logic [1:0] ot;
        logic [3:0] opc;
        logic [W-1:0] a, b;

        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.alu_ot = 2'd1; bus.alu_opcode = 4'd0;
        bus.op1 = 16'hFFFF; bus.op2 = 16'h0001; bus.out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs", 64'({bus.in_ready, bus.out_valid, pack_out()}), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", 64'(bus.in_ready), 64'd0);
        tick();
        @(negedge clk);
        check("ready_second_cycle", 64'(bus.in_ready), 64'd1);
        tick();

        // ADD wrap with carry
        bus.out_ready = 1'b1;
        got_q.delete(); got_cyc.delete();
        issue(2'd1, 4'd0, 16'hFFFF, 16'h0001);
        repeat (2) tick();
        check("add_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1)
            check("add_value", 64'(got_q[0]), 64'(mk(16'h0000, 16'h0, 16'h0, 0, 0, 0, 1, 0, 1, 1, 0)));

        // MUL fixed latency
        got_q.delete(); got_cyc.delete();
        issue(2'd1, 4'd4, 16'h1234, 16'h0100);
        repeat (W + 3) tick();
        check("mul_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            check("mul_value", 64'(got_q[0]), 64'(mk(16'h3400, 16'h0012, 16'h0, 0, 0, 0, 1, 0, 0, 0, 0)));
            check("mul_latency", 64'(got_cyc[0] - acc_cyc), 64'(W + 1));
        end

        // Back-to-back XOR then SHL
        got_q.delete(); got_cyc.delete();
        issue(2'd2, 4'd2, 16'hF0F0, 16'h0FF0);
        issue(2'd2, 4'd4, 16'h0001, 16'h0013);
        repeat (3) tick();
        check("b2b_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() >= 2) begin
            check("xor_value", 64'(got_q[0]), 64'(mk(16'hFF00, 16'h0, 16'h0, 0, 0, 0, 1, 0, 0, 0, 0)));
            check("shl_value", 64'(got_q[1]), 64'(mk(16'h0008, 16'h0, 16'h0, 0, 0, 0, 0, 1, 0, 0, 0)));
            check("b2b_gap", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
        end

        // SUB held while consumer stalls; second op waits
        got_q.delete(); got_cyc.delete();
        bus.out_ready = 1'b0;
        issue(2'd1, 4'd1, 16'h0003, 16'h0005);
        bus.in_valid = 1'b1; bus.alu_ot = 2'd2; bus.alu_opcode = 4'd0;
        bus.op1 = 16'h00FF; bus.op2 = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sub_stall", 64'({bus.out_valid, bus.in_ready, bus.alu_out, bus.carry}),
                  64'({1'b1, 1'b0, 16'hFFFE, 1'b1}));
            tick();
        end
        bus.out_ready = 1'b1;
        issue(2'd2, 4'd0, 16'h00FF, 16'h0F0F);
        repeat (2) tick();
        check("stall_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() >= 2) begin
            check("sub_value", 64'(got_q[0]), 64'(mk(16'hFFFE, 16'h0, 16'h0, 0, 0, 0, 0, 1, 1, 0, 0)));
            check("and_value", 64'(got_q[1]), 64'(mk(16'h000F, 16'h0, 16'h0, 0, 0, 0, 0, 1, 0, 0, 0)));
        end

        // Illegal class, then MUL killed by reset
        got_q.delete(); got_cyc.delete();
        issue(2'd3, 4'd0, 16'h0005, 16'h0005);
        repeat (2) tick();
        check("ill_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1)
            check("ill_value", 64'(got_q[0]), 64'(mk(16'h0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0, 1, 1)));
        got_q.delete(); got_cyc.delete();
        issue(2'd1, 4'd4, 16'h00FF, 16'h00FF);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < W + 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        check("mul_discarded", 64'({seen, got_q.size() != 0}), 64'd0);

        // Randomized traffic with a random consumer
        rnd_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            ot  = 2'($urandom_range(0, 3));
            opc = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin ot = 2'd1; opc = 4'd4; end
            a = pick();
            b = ($urandom_range(0, 7) == 0) ? a : pick();
            issue(ot, opc, a, b);
        end
        rnd_rdy = 1'b0;
        bus.out_ready = 1'b1;
        repeat (W + 6) tick();
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
